// File: rtl/debug_uart_cmd_parser.sv
// rtl/debug_uart_cmd_parser.sv - debug UART command frame parser
//
// Assembles frames of the form SOF, CMD, LEN, LEN payload bytes, CHK from the
// UART receiver byte stream. CHK is the XOR of CMD, LEN and the payload bytes.
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Rst_n        synchronous active-low reset
//   i_Rx_DV        single-cycle byte-valid pulse from the UART receiver
//   i_Rx_Byte      received byte, valid with i_Rx_DV
//   i_Frame_Ready  consumer accepts the held frame
//   o_Frame_Valid  frame outputs valid, held until accepted
//   o_Cmd          command byte
//   o_Len          payload length, 0..MAX_LEN
//   o_Payload      payload, byte k at [8k+7:8k], unused bytes zero
//   o_Chk_Err      one-cycle pulse on checksum mismatch
//   o_Len_Err      one-cycle pulse when LEN > MAX_LEN
//   o_Timeout      one-cycle pulse on inter-byte timeout abort
//   o_Overrun      one-cycle pulse when a byte arrives while a frame is held

module debug_uart_cmd_parser #(
    parameter int         MAX_LEN      = 8,
    parameter int         TIMEOUT_CLKS = 3480,
    parameter logic [7:0] SOF_BYTE     = 8'hAA
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    input  logic                 i_Frame_Ready,
    output logic                 o_Frame_Valid,
    output logic [7:0]           o_Cmd,
    output logic [3:0]           o_Len,
    output logic [8*MAX_LEN-1:0] o_Payload,
    output logic                 o_Chk_Err,
    output logic                 o_Len_Err,
    output logic                 o_Timeout,
    output logic                 o_Overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CLKS - 1);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [7:0]  acc;
    logic [3:0]  idx;
    logic        timed;

    // States in which the inter-byte timeout is armed.
    assign timed = (state == S_CMD) || (state == S_LEN) ||
                   (state == S_PAYLOAD) || (state == S_CHK);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            acc           <= '0;
            idx           <= '0;
            o_Frame_Valid <= 1'b0;
            o_Cmd         <= '0;
            o_Len         <= '0;
            o_Payload     <= '0;
            o_Chk_Err     <= 1'b0;
            o_Len_Err     <= 1'b0;
            o_Timeout     <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            o_Chk_Err <= 1'b0;
            o_Len_Err <= 1'b0;
            o_Timeout <= 1'b0;
            o_Overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                        state     <= S_CMD;
                        o_Payload <= '0;
                    end
                end
                S_CMD: begin
                    if (i_Rx_DV) begin
                        o_Cmd <= i_Rx_Byte;
                        acc   <= i_Rx_Byte;
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte > 8'(MAX_LEN)) begin
                            o_Len_Err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            o_Len <= i_Rx_Byte[3:0];
                            acc   <= acc ^ i_Rx_Byte;
                            idx   <= '0;
                            state <= (i_Rx_Byte == 8'd0) ? S_CHK : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (idx == k[3:0]) begin
                                o_Payload[8*k +: 8] <= i_Rx_Byte;
                            end
                        end
                        acc <= acc ^ i_Rx_Byte;
                        idx <= idx + 4'd1;
                        if ((idx + 4'd1) == o_Len) begin
                            state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (i_Rx_DV) begin
                        if (i_Rx_Byte == acc) begin
                            o_Frame_Valid <= 1'b1;
                            state         <= S_HOLD;
                        end else begin
                            o_Chk_Err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (i_Frame_Ready) begin
                        o_Frame_Valid <= 1'b0;
                        // A byte in the handshake cycle is judged as if already idle,
                        // so an SOF here starts the next frame without loss.
                        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                            state     <= S_CMD;
                            o_Payload <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (i_Rx_DV) begin
                        o_Overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Counter is zero on entry to every timed state because it is held
            // clear outside them and cleared by the byte that causes the entry.
            if (timed && !i_Rx_DV) begin
                if (tmo_cnt == TO_LAST) begin
                    o_Timeout <= 1'b1;
                    state     <= S_IDLE;
                    tmo_cnt   <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_debug_uart_cmd_parser.sv
// tb/tb_debug_uart_cmd_parser.sv - self-checking bench for debug_uart_cmd_parser
module tb_debug_uart_cmd_parser;

    localparam int         MAX_LEN = 8;
    localparam int         T       = 3480;
    localparam logic [7:0] SOF     = 8'hAA;
    localparam int         PW      = 8 * MAX_LEN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          ready = 1'b0;
    logic          o_valid;
    logic [7:0]    o_cmd;
    logic [3:0]    o_len;
    logic [PW-1:0] o_pl;
    logic          o_chk, o_lerr, o_tmo, o_ovr;

    debug_uart_cmd_parser #(
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CLKS(T),
        .SOF_BYTE(SOF)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .i_Rx_DV(dv),
        .i_Rx_Byte(rx_byte),
        .i_Frame_Ready(ready),
        .o_Frame_Valid(o_valid),
        .o_Cmd(o_cmd),
        .o_Len(o_len),
        .o_Payload(o_pl),
        .o_Chk_Err(o_chk),
        .o_Len_Err(o_lerr),
        .o_Timeout(o_tmo),
        .o_Overrun(o_ovr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic          m_in_frame = 1'b0;
    logic          m_held = 1'b0;
    int            m_gap = 0;
    logic [7:0]    q[$];
    logic [7:0]    x;
    logic          take;
    logic          e_valid = 1'b0, e_all = 1'b0;
    logic [7:0]    e_cmd = '0;
    logic [3:0]    e_len = '0;
    logic [PW-1:0] e_pl = '0;
    logic          e_chk = 1'b0, e_lerr = 1'b0, e_tmo = 1'b0, e_ovr = 1'b0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_in_frame = 1'b0; m_held = 1'b0; m_gap = 0; q.delete();
            e_valid = 1'b0; e_cmd = '0; e_len = '0; e_pl = '0;
            e_chk = 1'b0; e_lerr = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
            e_all = 1'b1;
        end else begin
            e_all = 1'b0;
            e_chk = 1'b0; e_lerr = 1'b0; e_tmo = 1'b0; e_ovr = 1'b0;
            take = dv;
            if (m_held) begin
                if (ready) begin
                    m_held = 1'b0;
                    e_valid = 1'b0;
                end else begin
                    if (dv) e_ovr = 1'b1;
                    take = 1'b0;
                end
            end
            if (take) begin
                if (!m_in_frame) begin
                    if (rx_byte == SOF) begin
                        m_in_frame = 1'b1; q.delete(); m_gap = 0;
                    end
                end else begin
                    m_gap = 0;
                    q.push_back(rx_byte);
                    if (q.size() == 2 && int'(rx_byte) > MAX_LEN) begin
                        e_lerr = 1'b1; m_in_frame = 1'b0;
                    end else if (q.size() >= 3 && q.size() == int'(q[1]) + 3) begin
                        x = 8'h00;
                        for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
                        if (x == rx_byte) begin
                            m_held = 1'b1; e_valid = 1'b1;
                            e_cmd = q[0]; e_len = q[1][3:0]; e_pl = '0;
                            for (int i = 0; i < int'(q[1]); i++) e_pl[8*i +: 8] = q[2+i];
                        end else begin
                            e_chk = 1'b1;
                        end
                        m_in_frame = 1'b0;
                    end
                end
            end else if (m_in_frame) begin
                m_gap++;
                if (m_gap == T) begin
                    e_tmo = 1'b1; m_in_frame = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    int         frames = 0, valid_hi = 0, ovr_cnt = 0, chk_cnt = 0, lerr_cnt = 0, tmo_cnt = 0;
    int         tmo_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_cmd = '0;
    logic [3:0] last_len = '0;
    logic [PW-1:0] last_pl = '0;

    always @(negedge clk) begin
        check("valid", o_valid, e_valid);
        check("chk_err", o_chk, e_chk);
        check("len_err", o_lerr, e_lerr);
        check("timeout", o_tmo, e_tmo);
        check("overrun", o_ovr, e_ovr);
        if (e_valid || e_all) begin
            check("cmd", o_cmd, e_cmd);
            check("len", o_len, e_len);
            check("payload", o_pl, e_pl);
        end
        if (o_valid && !prev_valid) begin
            frames++; last_cmd = o_cmd; last_len = o_len; last_pl = o_pl;
        end
        if (o_valid) valid_hi++;
        if (o_ovr) ovr_cnt++;
        if (o_chk) chk_cnt++;
        if (o_lerr) lerr_cnt++;
        if (o_tmo) begin tmo_cnt++; tmo_cyc = cyc; end
        prev_valid = o_valid;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        dv = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap);
        foreach (s[i]) send(s[i], gap);
    endtask

    int f0, v0, o0, c0, l0, t0, d0;

    initial begin
        idle(3);
        check("rst_valid", o_valid, 1'b0);
        check("rst_payload", o_pl, '0);
        rst_n = 1'b1;
        idle(2);

        // 1: basic frame, ready held high
        ready = 1'b1; f0 = frames; v0 = valid_hi;
        send_seq({8'hAA, 8'h10, 8'h02, 8'h12, 8'h34, 8'h34}, 1);
        idle(3);
        check("t1_frames", frames - f0, 1);
        check("t1_valid_cycles", valid_hi - v0, 1);
        check("t1_cmd", last_cmd, 8'h10);
        check("t1_len", last_len, 4'd2);
        check("t1_payload", last_pl, 64'h3412);

        // 2: held frame with overrun
        ready = 1'b0; f0 = frames; o0 = ovr_cnt;
        send_seq({8'hAA, 8'h05, 8'h00, 8'h05}, 2);
        v0 = valid_hi;
        idle(20);
        send(8'h55, 0);
        ready = 1'b1;
        idle(3);
        check("t2_hold_cycles", valid_hi - v0, 22);
        check("t2_overrun", ovr_cnt - o0, 1);
        check("t2_cmd", last_cmd, 8'h05);
        check("t2_len", last_len, 4'd0);
        check("t2_frames", frames - f0, 1);

        // 3: checksum error then a good frame
        f0 = frames; c0 = chk_cnt;
        send_seq({8'hAA, 8'h10, 8'h02, 8'h12, 8'h34, 8'h00}, 1);
        idle(2);
        check("t3_chk_err", chk_cnt - c0, 1);
        check("t3_no_frame", frames - f0, 0);
        send_seq({8'hAA, 8'h05, 8'h00, 8'h05}, 1);
        idle(2);
        check("t3_recover", frames - f0, 1);
        check("t3_cmd", last_cmd, 8'h05);

        // 4: length error, junk byte, then good frame
        f0 = frames; l0 = lerr_cnt;
        send_seq({8'hAA, 8'h01, 8'h09}, 1);
        idle(2);
        check("t4_len_err", lerr_cnt - l0, 1);
        send_seq({8'h33, 8'hAA, 8'h01, 8'h00, 8'h01}, 1);
        idle(2);
        check("t4_frames", frames - f0, 1);
        check("t4_cmd", last_cmd, 8'h01);
        check("t4_len", last_len, 4'd0);

        // 5: timeout, then a byte landing on the expiry cycle
        t0 = tmo_cnt;
        send_seq({8'hAA, 8'h10}, 0);
        d0 = cyc;
        idle(T + 5);
        check("t5_timeout", tmo_cnt - t0, 1);
        check("t5_timeout_latency", tmo_cyc - d0, T);
        t0 = tmo_cnt; f0 = frames;
        send_seq({8'hAA, 8'h10}, 0);
        send(8'h01, T - 1);
        send_seq({8'h42, 8'h53}, 0);
        idle(3);
        check("t5_no_timeout", tmo_cnt - t0, 0);
        check("t5_frames", frames - f0, 1);
        check("t5_payload", last_pl, 64'h42);

        // 6: reset mid-payload, then fresh frame
        f0 = frames;
        send_seq({8'hAA, 8'h10, 8'h03, 8'h11}, 1);
        rst_n = 1'b0;
        idle(1);
        check("t6_rst_cmd", o_cmd, 8'h00);
        check("t6_rst_payload", o_pl, '0);
        idle(2);
        rst_n = 1'b1;
        send_seq({8'hAA, 8'h22, 8'h01, 8'h77, 8'h54}, 1);
        idle(2);
        check("t6_frames", frames - f0, 1);
        check("t6_cmd", last_cmd, 8'h22);
        check("t6_payload", last_pl, 64'h77);

        // 6b: ready and SOF in the same hold cycle
        ready = 1'b0; f0 = frames; o0 = ovr_cnt;
        send_seq({8'hAA, 8'h30, 8'h00, 8'h30}, 1);
        idle(3);
        ready = 1'b1;
        send(8'hAA, 0);
        send_seq({8'h40, 8'h01, 8'h99, 8'hD8}, 0);
        idle(3);
        check("t6b_frames", frames - f0, 2);
        check("t6b_overrun", ovr_cnt - o0, 0);
        check("t6b_cmd", last_cmd, 8'h40);
        check("t6b_payload", last_pl, 64'h99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
